// File: rtl/apb_uart_rx.sv
// APB3 UART receiver: 8N1 at 16x oversampling, with a receive FIFO and status flags.
// Registers: DATA (pop on read), STATUS (flags plus W1C), BAUD (oversample divisor).
`timescale 1ns/1ps
module apb_uart_rx #(
  parameter logic [15:0] DEFAULT_DIV = 16'd27,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        RX,
  output logic        INT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t          state, state_nxt;
  logic            rx_s1, rx_s2, rx_prev, fall;
  logic [15:0]     div_reg, div_cnt, div_eff;
  logic            tick;
  logic [3:0]      tcnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            tcnt_clr, sample_bit, push_req, ferr_det;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [4:0]      count5;
  logic            empty, full, push, pop, ovr_set;
  logic            ferr, ovr;
  logic            access, rd_acc, wr_acc;
  logic [1:0]      addr;
  logic [31:0]     rdata;
  logic            unused;

  assign unused = ^{PADDR[7:4], PADDR[1:0], PWDATA[31:16]};

  // RX synchronizer; rx_prev supplies the falling-edge reference
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end
  assign fall = rx_prev & ~rx_s2;

  // Down-counter reloads from the live divisor, so BAUD writes apply at the next reload
  assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;
  assign tick    = (div_cnt == 16'd0);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) div_cnt <= 16'd0;
    else if (tick) div_cnt <= div_eff - 16'd1;
    else           div_cnt <= div_cnt - 16'd1;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (tick && tcnt == 4'd7) state_nxt = rx_s2 ? IDLE : DATA;
      DATA:  if (tick && tcnt == 4'd15 && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (tick && tcnt == 4'd15) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tcnt_clr   = 1'b0;
    sample_bit = 1'b0;
    push_req   = 1'b0;
    ferr_det   = 1'b0;
    case (state)
      IDLE:  tcnt_clr = fall;
      START: tcnt_clr = tick && (tcnt == 4'd7);
      DATA:  sample_bit = tick && (tcnt == 4'd15);
      STOP: begin
        push_req = tick && (tcnt == 4'd15) && rx_s2;
        ferr_det = tick && (tcnt == 4'd15) && !rx_s2;
      end
      default: ;
    endcase
  end

  // Clearing at the start midpoint lets tcnt wrap 15->0 for every later sample point
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      tcnt    <= 4'd0;
      bit_idx <= 3'd0;
    end else begin
      if (tcnt_clr)                    tcnt <= 4'd0;
      else if (tick && state != IDLE)  tcnt <= tcnt + 4'd1;
      if (tcnt_clr)        bit_idx <= 3'd0;
      else if (sample_bit) bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (sample_bit) shreg <= {rx_s2, shreg[7:1]};
  end

  assign access = PSEL & PENABLE;
  assign rd_acc = access & ~PWRITE;
  assign wr_acc = access & PWRITE;
  assign addr   = PADDR[3:2];

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd_acc && (addr == 2'd0) && !empty;
  assign push    = push_req && (!full || pop);
  assign ovr_set = push_req && full && !pop;

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flag set takes priority over a same-cycle W1C
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      ferr    <= 1'b0;
      ovr     <= 1'b0;
      div_reg <= DEFAULT_DIV;
    end else begin
      if (ferr_det) ferr <= 1'b1;
      else if (wr_acc && addr == 2'd1 && PWDATA[2]) ferr <= 1'b0;
      if (ovr_set) ovr <= 1'b1;
      else if (wr_acc && addr == 2'd1 && PWDATA[3]) ovr <= 1'b0;
      if (wr_acc && addr == 2'd2) div_reg <= PWDATA[15:0];
    end
  end

  assign count5 = 5'(count);

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    if (!empty) rdata = {24'b0, mem[rd_ptr]};
      2'd1:    rdata = {23'b0, count5, ovr, ferr, full, ~empty};
      2'd2:    rdata = {16'b0, div_reg};
      default: rdata = '0;
    endcase
  end

  // Combinational outputs are held low while reset is asserted
  assign PRDATA  = (PRESETN && rd_acc) ? rdata : 32'd0;
  assign PSLVERR = PRESETN && access && (addr == 2'd3);
  assign PREADY  = 1'b1;
  assign INT     = ~empty | ferr | ovr;

endmodule

// File: doc/apb_uart_rx.md
APB_UART_RX -- requirements
Module: apb_uart_rx

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 16'd27, reset value of the oversample divisor (50 MHz / (115200*16)).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO depth in bytes (power of two, 2..16).
REQ-003 SHALL have port PCLK  input  1  single clock for all logic.
REQ-004 SHALL have port PRESETN  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB3 completer controls.
REQ-006 SHALL have port PADDR  input  8  byte address; only bits [3:2] are decoded.
REQ-007 SHALL have port PWDATA  input  32  write data.
REQ-008 SHALL have port PRDATA  output  32  read data.
REQ-009 SHALL have ports PREADY, PSLVERR  output  1 each  APB3 completion and error.
REQ-010 SHALL have port RX  input  1  asynchronous serial input, 8N1, idle high.
REQ-011 SHALL have port INT  output  1  level interrupt = FIFO not empty OR FERR OR OVR.

Function
REQ-012 SHALL pass RX through a 2-flop synchronizer before any use.
REQ-013 SHALL generate a 1-cycle oversample tick every DIV PCLK cycles; a DIV value of 0 SHALL behave as 1.
REQ-014 SHALL implement states IDLE, START, DATA, STOP; all bit timing counts ticks (16 per bit).
REQ-015 IDLE->START on a synchronized high-to-low RX transition; the tick counter clears.
REQ-016 START: at tick 8, RX low -> DATA; RX high -> IDLE (glitch rejected, no flags change).
REQ-017 DATA: sample RX every 16 ticks after the start midpoint, LSB first; after bit 7 -> STOP.
REQ-018 STOP: sample at the midpoint; RX high -> push byte; RX low -> discard byte, set FERR; then IDLE.
REQ-019 On push with FIFO full, the byte SHALL be discarded and OVR set; FIFO contents are unchanged.
REQ-020 Register 0x0 DATA (RO): read returns {24'b0, head byte} and pops; read when empty returns 0, no pop.
REQ-021 Register 0x4 STATUS: bit0 not-empty, bit1 full, bit2 FERR, bit3 OVR, bits[8:4] count; writing 1 to bit2/bit3 clears that flag.
REQ-022 Register 0x8 BAUD (RW): bits[15:0] = DIV; a write takes effect at the next tick-counter reload.
REQ-023 Register 0xC: reserved; any access SHALL assert PSLVERR in the access phase, with PRDATA=0 and no side effects.
REQ-024 PREADY SHALL be 1 permanently; every transfer completes in zero wait states (setup + access).
REQ-025 Register side effects SHALL occur only in the cycle where PSEL=PENABLE=1.
REQ-026 PRDATA SHALL be 0 when no read access phase is active.
REQ-027 A simultaneous push and pop in one cycle SHALL both complete, leaving the count unchanged, even when full.
REQ-028 A flag set and a W1C clear of the same flag in one cycle: set wins.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-030 PRESETN low SHALL asynchronously force: state IDLE, FIFO empty, FERR=OVR=0, DIV=DEFAULT_DIV, synchronizer flops=1, PRDATA=0, PSLVERR=0, INT=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; after release, the receiver waits for a new falling edge, and the abandoned byte is never pushed.

Verification
REQ-032 With DIV=27, send 0xA5 at 115200 baud -> STATUS=0x011 and INT=1; DATA read returns 0xA5; STATUS then reads 0x000.
REQ-033 Send a 0.25-bit low pulse on RX -> no push, no flags, state returns to IDLE.
REQ-034 Send 0x3C with the stop bit low -> FERR=1, FIFO empty; write STATUS=0x4 -> FERR=0 and INT=0.
REQ-035 Send 9 bytes 0x01..0x09 with FIFO_DEPTH=8 -> full=1, OVR=1; reads return 0x01..0x08; a 9th read returns 0.
REQ-036 Fill to 8, then pop in the same cycle a new byte pushes -> count stays 8 and OVR stays 0; access to 0xC -> PSLVERR=1.
REQ-037 Assert PRESETN low during bit 4 of a frame -> all outputs at their reset values; the next full frame 0x5A is received correctly.
